// File: rtl/ifetch_pkg.sv
// Shared fetch-side definitions: FSM state encoding and default widths/depths.
package riscv_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus: pc/stall handshake toward the core, request/response toward
// instruction memory, and the instruction stream toward the decoder.
interface ifetch_if import riscv_pkg::*; #(
  parameter int XLEN = DEF_XLEN
) ();

  logic [XLEN-1:0] pc;
  logic            fetch_en;
  logic            fetch_stall;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  modport master (
    input  pc, fetch_en, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output fetch_stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output pc, fetch_en, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  fetch_stall, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries in fetch order.
// Head output reads as zero whenever the buffer is empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; clear wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents only matter while counted as valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory request at a time, responses
// buffered in a small FIFO, flush discards buffered and in-flight data.
module ifetch import riscv_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int XLEN       = DEF_XLEN
) (
  input  logic     clk,
  input  logic     rst,
  ifetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic            kill_q;
  logic            kill_nxt;
  logic            accept;
  logic            push;
  logic            pop;
  logic            room;
  logic            head_vld;
  logic [XLEN-1:0] addr_p0;
  logic [CW-1:0]   count;
  logic [2*XLEN-1:0] head;

  // A slot is free only if nothing is in flight, which holds in IDLE,
  // so checking occupancy at accept reserves the slot for the response.
  assign room     = (count < CW'(FIFO_DEPTH));
  assign head_vld = (count != '0);
  assign pop      = head_vld && bus.instr_ready;

  // State register; kill_q marks a request flushed while still awaiting gnt
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      kill_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      kill_q <= kill_nxt;
    end
  end

  // Stage p0: fetch address captured at accept, held through REQ/WAIT
  always_ff @(posedge clk) begin
    if (accept) addr_p0 <= bus.pc;
  end

  // Next-state, accept and push decode
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill_q;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fetch_en && !bus.flush && room) begin
          accept    = 1'b1;
          state_nxt = REQ;
          kill_nxt  = 1'b0;
        end
      end
      REQ: begin
        if (bus.imem_gnt) begin
          state_nxt = (kill_q || bus.flush) ? DRAIN : WAIT;
          kill_nxt  = 1'b0;
        end else if (bus.flush) begin
          kill_nxt  = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_nxt = IDLE;
          push      = !bus.flush;
        end else if (bus.flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        kill_nxt  = 1'b0;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({addr_p0, bus.imem_rdata}),
    .pop       (pop),
    .clear     (bus.flush),
    .head      (head),
    .count     (count)
  );

  assign bus.fetch_stall = bus.fetch_en && !accept;
  assign bus.imem_req    = (state == REQ);
  assign bus.imem_addr   = (state == REQ) ? addr_p0 : '0;
  assign bus.instr_valid = head_vld;
  assign bus.instr_pc    = head[2*XLEN-1:XLEN];
  assign bus.instr       = head[XLEN-1:0];

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, single fetch, backpressure, gnt delay,
// flush in REQ/WAIT, flush with fetch/pop, reset mid-transaction.
module tb_ifetch;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ifetch_if #(.XLEN(32)) bus ();

  ifetch #(.FIFO_DEPTH(2), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    cyc(); bus.pc = a; bus.fetch_en = 1'b1;
    smp(); chk("fo_accept_stall", bus.fetch_stall, 0);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("fo_req", bus.imem_req, 1); chk("fo_addr", bus.imem_addr, a);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = d;
    smp(); chk("fo_req_drop", bus.imem_req, 0);
    cyc(); bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
  endtask

  initial begin
    rst = 1'b0;
    bus.pc = '0; bus.fetch_en = 1'b0; bus.flush = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;

    // Reset held for two edges
    cyc(); cyc();
    smp();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_stall", bus.fetch_stall, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    cyc(); rst = 1'b1;

    // Single fetch, gnt in first REQ cycle
    bus.instr_ready = 1'b1;
    cyc(); bus.pc = 32'h10; bus.fetch_en = 1'b1;
    smp(); chk("sf_stall", bus.fetch_stall, 0); chk("sf_req_n", bus.imem_req, 0);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("sf_req", bus.imem_req, 1); chk("sf_addr", bus.imem_addr, 32'h10);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00500093;
    smp(); chk("sf_valid_early", bus.instr_valid, 0);
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("sf_valid", bus.instr_valid, 1);
    chk("sf_instr", bus.instr, 32'h00500093); chk("sf_pc", bus.instr_pc, 32'h10);
    cyc();
    smp(); chk("sf_popped", bus.instr_valid, 0);

    // Backpressure: two buffered, third stalls, then in-order drain
    bus.instr_ready = 1'b0;
    fetch_one(32'h0, 32'h11111111);
    smp(); chk("bp_head0_pc", bus.instr_pc, 32'h0);
    fetch_one(32'h4, 32'h22222222);
    bus.pc = 32'h8; bus.fetch_en = 1'b1;
    smp(); chk("bp_stall_full", bus.fetch_stall, 1);
    chk("bp_head_hold", bus.instr, 32'h11111111);
    cyc(); bus.instr_ready = 1'b1;
    smp(); chk("bp_stall_still", bus.fetch_stall, 1); chk("bp_pop0_pc", bus.instr_pc, 32'h0);
    cyc();
    smp(); chk("bp_accept8", bus.fetch_stall, 0); chk("bp_pop1_pc", bus.instr_pc, 32'h4);
    chk("bp_pop1_instr", bus.instr, 32'h22222222);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("bp_req8", bus.imem_req, 1); chk("bp_addr8", bus.imem_addr, 32'h8);
    chk("bp_empty", bus.instr_valid, 0);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h33333333;
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("bp_v8", bus.instr_valid, 1); chk("bp_pc8", bus.instr_pc, 32'h8);
    chk("bp_instr8", bus.instr, 32'h33333333);
    cyc();

    // Gnt three cycles late: address held four cycles
    cyc(); bus.pc = 32'h20; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0; bus.pc = 32'h5C;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("gd_req_wait", bus.imem_req, 1); chk("gd_addr_wait", bus.imem_addr, 32'h20);
      cyc();
    end
    bus.imem_gnt = 1'b1;
    smp(); chk("gd_req_gnt", bus.imem_req, 1); chk("gd_addr_gnt", bus.imem_addr, 32'h20);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFEF00D;
    smp(); chk("gd_req_done", bus.imem_req, 0);
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("gd_valid", bus.instr_valid, 1); chk("gd_instr", bus.instr, 32'hCAFEF00D);
    chk("gd_pc", bus.instr_pc, 32'h20);
    cyc();
    smp(); chk("gd_single", bus.instr_valid, 0);

    // Flush in WAIT, late rvalid discarded, next fetch correct
    cyc(); bus.pc = 32'h30; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.flush = 1'b1;
    cyc(); bus.flush = 1'b0; bus.pc = 32'h40; bus.fetch_en = 1'b1;
    smp(); chk("fw_drain_stall", bus.fetch_stall, 1);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    smp(); chk("fw_drain_stall2", bus.fetch_stall, 1); chk("fw_no_req", bus.imem_req, 0);
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("fw_accept", bus.fetch_stall, 0); chk("fw_dropped", bus.instr_valid, 0);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("fw_addr40", bus.imem_addr, 32'h40); chk("fw_dropped2", bus.instr_valid, 0);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00A00113;
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("fw_valid", bus.instr_valid, 1); chk("fw_instr", bus.instr, 32'h00A00113);
    chk("fw_pc", bus.instr_pc, 32'h40);
    cyc();

    // Flush + fetch_en + pop in the same cycle
    bus.instr_ready = 1'b0;
    fetch_one(32'h50, 32'h55555555);
    bus.pc = 32'h60; bus.fetch_en = 1'b1; bus.flush = 1'b1; bus.instr_ready = 1'b1;
    smp(); chk("ff_stall", bus.fetch_stall, 1); chk("ff_head_pc", bus.instr_pc, 32'h50);
    cyc(); bus.fetch_en = 1'b0; bus.flush = 1'b0;
    smp(); chk("ff_no_req", bus.imem_req, 0); chk("ff_empty", bus.instr_valid, 0);
    chk("ff_instr_zero", bus.instr, 0);

    // Flush in WAIT coinciding with rvalid: drop and return to IDLE
    cyc(); bus.pc = 32'h70; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0BAD0;
    bus.flush = 1'b1;
    cyc(); bus.imem_rvalid = 1'b0; bus.flush = 1'b0; bus.pc = 32'h74; bus.fetch_en = 1'b1;
    smp(); chk("fr_idle_accept", bus.fetch_stall, 0); chk("fr_dropped", bus.instr_valid, 0);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("fr_addr74", bus.imem_addr, 32'h74);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h74747474;
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("fr_pc74", bus.instr_pc, 32'h74); chk("fr_instr74", bus.instr, 32'h74747474);
    cyc();

    // Flush in REQ: request kept until gnt, then response drained
    cyc(); bus.pc = 32'h80; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0; bus.flush = 1'b1;
    smp(); chk("fq_req_kept", bus.imem_req, 1); chk("fq_addr", bus.imem_addr, 32'h80);
    cyc(); bus.flush = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("fq_req_kept2", bus.imem_req, 1);
    cyc(); bus.imem_gnt = 1'b0; bus.pc = 32'h84; bus.fetch_en = 1'b1;
    smp(); chk("fq_drain_stall", bus.fetch_stall, 1);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBADBAD00;
    smp(); chk("fq_drain_stall2", bus.fetch_stall, 1);
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("fq_accept", bus.fetch_stall, 0); chk("fq_dropped", bus.instr_valid, 0);
    cyc(); bus.fetch_en = 1'b0; bus.imem_gnt = 1'b1;
    smp(); chk("fq_addr84", bus.imem_addr, 32'h84);
    cyc(); bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h84848484;
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("fq_instr84", bus.instr, 32'h84848484); chk("fq_pc84", bus.instr_pc, 32'h84);
    cyc();

    // Reset mid-transaction: request abandoned, stray rvalid ignored
    cyc(); bus.pc = 32'h90; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0; rst = 1'b0;
    smp(); chk("mr_req_before", bus.imem_req, 1);
    cyc(); rst = 1'b1;
    smp(); chk("mr_req_gone", bus.imem_req, 0); chk("mr_addr_zero", bus.imem_addr, 0);
    cyc(); bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h99999999;
    cyc(); bus.imem_rvalid = 1'b0;
    smp(); chk("mr_ignored", bus.instr_valid, 0); chk("mr_stall", bus.fetch_stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, meaning: instruction buffer entries (power of two, ≥2).
REQ-002 Parameter XLEN, default 32, meaning: address and instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 pc  input  XLEN  fetch address from the pc register.
REQ-006 fetch_en  input  1  request to fetch address pc this cycle.
REQ-007 fetch_stall  output  1  fetch_en not accepted this cycle; pc register SHALL hold.
REQ-008 flush  input  1  discard buffered and in-flight instructions (branch/jump redirect).
REQ-009 imem_req  output  1  memory request valid.
REQ-010 imem_addr  output  XLEN  memory request address.
REQ-011 imem_gnt  input  1  memory accepted request.
REQ-012 imem_rvalid  input  1  read data valid.
REQ-013 imem_rdata  input  XLEN  read data.
REQ-014 instr_valid  output  1  buffer head valid.
REQ-015 instr  output  XLEN  head instruction.
REQ-016 instr_pc  output  XLEN  address of head instruction.
REQ-017 instr_ready  input  1  consumer takes head when instr_valid && instr_ready.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ (imem_req high, awaiting gnt), WAIT (awaiting rvalid) and DRAIN (awaiting rvalid of a flushed request).
REQ-019 Accept = fetch_en && !flush && state==IDLE && count<FIFO_DEPTH; fetch_stall = fetch_en && !accept.
REQ-020 On accept at cycle N, pc SHALL be latched, and imem_req/imem_addr SHALL be asserted from cycle N+1 (IDLE->REQ).
REQ-021 imem_req and imem_addr SHALL stay stable in REQ until imem_gnt; a gnt in the first REQ cycle is legal; REQ->WAIT on gnt.
REQ-022 At most one request SHALL be outstanding; imem_rvalid is legal no earlier than the cycle after gnt.
REQ-023 In WAIT, imem_rvalid SHALL push {addr, rdata} into the FIFO, go to IDLE, and make instr_valid high the next cycle (rvalid-to-instr_valid latency 1).
REQ-024 A FIFO slot SHALL be reserved at accept, so a push never meets a full FIFO; push and pop in the same cycle leave count unchanged.
REQ-025 The FIFO SHALL deliver instructions in fetch order; head data SHALL remain stable while instr_valid && !instr_ready.
REQ-026 Flush SHALL empty the FIFO at the next edge, so instr_valid is low the following cycle.
REQ-027 Flush in REQ SHALL keep the request until gnt, then go to DRAIN; flush in WAIT SHALL go to DRAIN, unless rvalid arrives in the same cycle, in which case the data is dropped and the state goes to IDLE.
REQ-028 DRAIN SHALL discard rvalid data and return to IDLE; fetch_stall stays high meanwhile.
REQ-029 Flush with fetch_en in the same cycle: flush wins, the fetch is not accepted, and fetch_stall is high.
REQ-030 Pop with flush in the same cycle: the pop completes and the FIFO is empty afterwards.

Reset
REQ-031 With rst low at an edge, the state SHALL be IDLE, FIFO count 0, and imem_req, instr_valid and fetch_stall 0; imem_addr, instr and instr_pc SHALL be 0.
REQ-032 Reset mid-transaction SHALL abandon the request; rvalid for it after reset is ignored (the environment also resets the memory).
REQ-033 No output SHALL depend on an asynchronous reset path.

Structure
REQ-034 The package riscv_pkg SHALL hold the fetch state enum, the XLEN constant and the default FIFO_DEPTH.
REQ-035 One sub-module, fetch_fifo (synchronous FIFO with push, pop, clear, count), SHALL hold the {pc, instr} entries.

Verification
REQ-036 Reset: rst=0 for 2 cycles -> imem_req=0, instr_valid=0, fetch_stall=0.
REQ-037 Single fetch: pc=0x10, fetch_en 1 cycle, gnt on the first REQ cycle, rdata=0x00500093 next cycle -> instr_valid one cycle later, instr=0x00500093, instr_pc=0x10.
REQ-038 Backpressure: instr_ready=0, fetch 0x0,0x4,0x8 -> two entries buffered, fetch_stall=1 on the third; ready=1 -> 0x0 then 0x4 popped in order, then 0x8 accepted.
REQ-039 Gnt delay: gnt 3 cycles late -> imem_addr held at 0x20 for 4 cycles, single response.
REQ-040 Flush in WAIT: rvalid arrives 2 cycles after flush with 0xDEADBEEF -> never appears on instr; the next fetch 0x40 returns correctly.
REQ-041 Flush+fetch_en same cycle -> fetch_stall=1, no imem_req the next cycle.
